// File: rtl/armleosoc_axi_pkg.sv
// Shared AXI definitions for the armleosoc interconnect blocks.
//
// Contents:
//   state_t                         - arbiter FSM states {IDLE, ADDR, DATA}
//   OKAY / EXOKAY / SLVERR / DECERR - AXI RRESP/BRESP encodings
//   FIXED / INCR / WRAP             - AXI ARBURST/AWBURST encodings
package armleosoc_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

endpackage

// File: rtl/armleosoc_arbiter_select.sv
// Combinational winner selection shared by the read and write arbiters.
//
// Ports:
//   req     in  N          request vector, one bit per host
//   rr_ptr  in  IDX_WIDTH  host index where the search starts
//   winner  out IDX_WIDTH  first requesting host at or after rr_ptr (wrapping)
//   any_req out 1          at least one request bit is set
//
// With rr_ptr held at zero this degenerates to fixed priority (lowest index
// wins), so the same block serves both arbitration policies.
module armleosoc_arbiter_select #(
  parameter int N         = 2,
  parameter int IDX_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 any_req
);

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Once a winner is found later candidates are ignored.
      if (!any_req && req[(int'(rr_ptr) + k) % N]) begin
        winner  = IDX_WIDTH'((int'(rr_ptr) + k) % N);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/armleosoc_axi_read_arbiter.sv
// N-to-1 AXI4 read-channel arbiter, one outstanding burst at a time.
//
// Optional feature macro: ARMLEOSOC_AXI_ARBITER_ROUND_ROBIN_EN
//   defined   - round-robin arbitration; rr_ptr advances past each granted
//               host when its AR handshake completes
//   undefined - fixed priority, lowest host index wins
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   host_axi_ar*          per-host AR channels (packed, host i at slice i)
//   host_axi_r*           per-host R handshake, shared R payload
//   router_axi_ar*        downstream AR channel, fields of the granted host
//   router_axi_r*         downstream R channel
//   dbg_state             current FSM state, for observation only
//
// Handshake semantics: every channel follows AXI valid/ready rules; a
// transfer happens on a rising edge where both valid and ready are 1. The
// AR path is registered through state/grant_q (a request seen in IDLE is
// presented downstream on the next cycle); host arready and the whole R path
// are combinational pass-throughs gated by the grant.
module armleosoc_axi_read_arbiter
  import armleosoc_axi_pkg::*;
#(
  parameter int OPT_NUMBER_OF_HOSTS = 2,
  parameter int ADDR_WIDTH          = 34,
  parameter int ID_WIDTH            = 4,
  parameter int DATA_WIDTH          = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,

  input  logic [OPT_NUMBER_OF_HOSTS-1:0]            host_axi_arvalid,
  output logic [OPT_NUMBER_OF_HOSTS-1:0]            host_axi_arready,
  input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0] host_axi_araddr,
  input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]          host_axi_arlen,
  input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]          host_axi_arsize,
  input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]          host_axi_arburst,
  input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]   host_axi_arid,
  input  logic [OPT_NUMBER_OF_HOSTS-1:0]            host_axi_arlock,
  input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]          host_axi_arprot,

  output logic [OPT_NUMBER_OF_HOSTS-1:0]            host_axi_rvalid,
  input  logic [OPT_NUMBER_OF_HOSTS-1:0]            host_axi_rready,
  output logic [1:0]                                host_axi_rresp,
  output logic                                      host_axi_rlast,
  output logic [DATA_WIDTH-1:0]                     host_axi_rdata,
  output logic [ID_WIDTH-1:0]                       host_axi_rid,

  output logic                                      router_axi_arvalid,
  input  logic                                      router_axi_arready,
  output logic [ADDR_WIDTH-1:0]                     router_axi_araddr,
  output logic [7:0]                                router_axi_arlen,
  output logic [2:0]                                router_axi_arsize,
  output logic [1:0]                                router_axi_arburst,
  output logic [ID_WIDTH-1:0]                       router_axi_arid,
  output logic                                      router_axi_arlock,
  output logic [2:0]                                router_axi_arprot,

  input  logic                                      router_axi_rvalid,
  output logic                                      router_axi_rready,
  input  logic [1:0]                                router_axi_rresp,
  input  logic                                      router_axi_rlast,
  input  logic [DATA_WIDTH-1:0]                     router_axi_rdata,
  input  logic [ID_WIDTH-1:0]                       router_axi_rid,

  output state_t                                    dbg_state
);

  localparam int N    = OPT_NUMBER_OF_HOSTS;
  localparam int IDXW = $clog2(N);

  state_t            state_q;
  logic [IDXW-1:0]   grant_q;
  logic [IDXW-1:0]   rr_ptr;
  logic [IDXW-1:0]   winner;
  logic              any_req;

  armleosoc_arbiter_select #(
    .N         (N),
    .IDX_WIDTH (IDXW)
  ) u_select (
    .req     (host_axi_arvalid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ARMLEOSOC_AXI_ARBITER_ROUND_ROBIN_EN
  logic [IDXW-1:0] rr_ptr_q;

  // The host just granted moves to the back of the queue once its address
  // has been accepted downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (state_q == ADDR && router_axi_arready) begin
      rr_ptr_q <= (int'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // grant_q is frozen from IDLE until the burst's rlast handshake, so a host
  // dropping arvalid mid-transaction cannot redirect the R beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (router_axi_arready) state_q <= DATA;
        end
        DATA: begin
          if (router_axi_rvalid && router_axi_rready && router_axi_rlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    router_axi_arvalid = (state_q == ADDR);
    host_axi_arready   = '0;
    host_axi_rvalid    = '0;
    router_axi_rready  = 1'b0;
    if (state_q == ADDR) begin
      host_axi_arready[grant_q] = router_axi_arready;
    end
    if (state_q == DATA) begin
      host_axi_rvalid[grant_q] = router_axi_rvalid;
      router_axi_rready        = host_axi_rready[grant_q];
    end
  end

  // AR payload always follows grant_q, so out of reset it mirrors host 0.
  assign router_axi_araddr  = host_axi_araddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign router_axi_arlen   = host_axi_arlen[int'(grant_q)*8 +: 8];
  assign router_axi_arsize  = host_axi_arsize[int'(grant_q)*3 +: 3];
  assign router_axi_arburst = host_axi_arburst[int'(grant_q)*2 +: 2];
  assign router_axi_arid    = host_axi_arid[int'(grant_q)*ID_WIDTH +: ID_WIDTH];
  assign router_axi_arlock  = host_axi_arlock[grant_q];
  assign router_axi_arprot  = host_axi_arprot[int'(grant_q)*3 +: 3];

  // R payload is shared by all hosts; only the granted host's rvalid rises.
  assign host_axi_rresp = router_axi_rresp;
  assign host_axi_rlast = router_axi_rlast;
  assign host_axi_rdata = router_axi_rdata;
  assign host_axi_rid   = router_axi_rid;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_armleosoc_axi_read_arbiter.sv
// Self-checking bench for armleosoc_axi_read_arbiter (2 hosts).
// Follows ARMLEOSOC_AXI_ARBITER_ROUND_ROBIN_EN in the same way as the design.
module tb_armleosoc_axi_read_arbiter;
  import armleosoc_axi_pkg::*;

  localparam int N  = 2;
  localparam int AW = 34;
  localparam int IW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    host_axi_arvalid, host_axi_arready;
  logic [N*AW-1:0] host_axi_araddr;
  logic [N*8-1:0]  host_axi_arlen;
  logic [N*3-1:0]  host_axi_arsize;
  logic [N*2-1:0]  host_axi_arburst;
  logic [N*IW-1:0] host_axi_arid;
  logic [N-1:0]    host_axi_arlock;
  logic [N*3-1:0]  host_axi_arprot;
  logic [N-1:0]    host_axi_rvalid, host_axi_rready;
  logic [1:0]      host_axi_rresp;
  logic            host_axi_rlast;
  logic [DW-1:0]   host_axi_rdata;
  logic [IW-1:0]   host_axi_rid;
  logic            router_axi_arvalid, router_axi_arready;
  logic [AW-1:0]   router_axi_araddr;
  logic [7:0]      router_axi_arlen;
  logic [2:0]      router_axi_arsize;
  logic [1:0]      router_axi_arburst;
  logic [IW-1:0]   router_axi_arid;
  logic            router_axi_arlock;
  logic [2:0]      router_axi_arprot;
  logic            router_axi_rvalid, router_axi_rready;
  logic [1:0]      router_axi_rresp;
  logic            router_axi_rlast;
  logic [DW-1:0]   router_axi_rdata;
  logic [IW-1:0]   router_axi_rid;
  state_t          dbg_state;

  armleosoc_axi_read_arbiter #(
    .OPT_NUMBER_OF_HOSTS(N), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_axi_arvalid(host_axi_arvalid), .host_axi_arready(host_axi_arready),
    .host_axi_araddr(host_axi_araddr), .host_axi_arlen(host_axi_arlen),
    .host_axi_arsize(host_axi_arsize), .host_axi_arburst(host_axi_arburst),
    .host_axi_arid(host_axi_arid), .host_axi_arlock(host_axi_arlock),
    .host_axi_arprot(host_axi_arprot),
    .host_axi_rvalid(host_axi_rvalid), .host_axi_rready(host_axi_rready),
    .host_axi_rresp(host_axi_rresp), .host_axi_rlast(host_axi_rlast),
    .host_axi_rdata(host_axi_rdata), .host_axi_rid(host_axi_rid),
    .router_axi_arvalid(router_axi_arvalid), .router_axi_arready(router_axi_arready),
    .router_axi_araddr(router_axi_araddr), .router_axi_arlen(router_axi_arlen),
    .router_axi_arsize(router_axi_arsize), .router_axi_arburst(router_axi_arburst),
    .router_axi_arid(router_axi_arid), .router_axi_arlock(router_axi_arlock),
    .router_axi_arprot(router_axi_arprot),
    .router_axi_rvalid(router_axi_rvalid), .router_axi_rready(router_axi_rready),
    .router_axi_rresp(router_axi_rresp), .router_axi_rlast(router_axi_rlast),
    .router_axi_rdata(router_axi_rdata), .router_axi_rid(router_axi_rid),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model state ----------------
  int            errors = 0;
  int            checks = 0;
  int            rr_model = 0;     // next host to favour (stays 0 for fixed priority)
  logic [N-1:0]  pend;             // hosts currently holding arvalid
  logic [AW-1:0] a_addr[N];
  logic [7:0]    a_len[N];
  logic [2:0]    a_size[N];
  logic [1:0]    a_burst[N];
  logic [IW-1:0] a_id[N];
  logic          a_lock[N];
  logic [2:0]    a_prot[N];
  logic [DW-1:0] exp_q[$];         // R beats the granted host still has to receive

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First pending host at or after rr_model, wrapping around.
  function automatic int pick(input logic [N-1:0] p);
    for (int k = 0; k < N; k++) begin
      if (p[(rr_model + k) % N]) return (rr_model + k) % N;
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_req(input int h);
    a_addr[h]  = {2'($urandom_range(0, 3)), 32'($urandom)};
    a_len[h]   = 8'($urandom_range(0, 3));
    a_size[h]  = 3'($urandom_range(0, 2));
    a_burst[h] = 2'($urandom_range(0, 2));
    a_id[h]    = IW'($urandom);
    a_lock[h]  = 1'($urandom);
    a_prot[h]  = 3'($urandom);
  endtask

  task automatic drive_ar();
    for (int h = 0; h < N; h++) begin
      host_axi_araddr[h*AW +: AW] = a_addr[h];
      host_axi_arlen[h*8 +: 8]    = a_len[h];
      host_axi_arsize[h*3 +: 3]   = a_size[h];
      host_axi_arburst[h*2 +: 2]  = a_burst[h];
      host_axi_arid[h*IW +: IW]   = a_id[h];
      host_axi_arlock[h]          = a_lock[h];
      host_axi_arprot[h*3 +: 3]   = a_prot[h];
    end
    host_axi_arvalid = pend;
  endtask

  // One complete burst, entered in an IDLE cycle just after a rising edge.
  // ar_wait: cycles router arready is held low; stall: randomise rvalid/rready;
  // raise: hosts that start requesting during the R phase; rst_beat: beat
  // index during which reset is asserted (-1 for none).
  task automatic run_txn(input int ar_wait, input bit stall, input logic [1:0] last_resp,
                         input logic [N-1:0] raise, input int rst_beat, output int granted);
    int w, bi, nb, cyc, got;
    bit done;
    logic [IW-1:0] exp_id;
    logic [63:0] exp_ar;
    logic [DW-1:0] beats[$];
    logic [DW-1:0] e;
    logic [N-1:0] rdy;

    w = pick(pend);
    granted = w;
    drive_ar();
    #1;
    check("idle_arvalid", router_axi_arvalid, 0);
    @(posedge clk); #1;
    exp_ar = {a_addr[w], a_len[w], a_size[w], a_burst[w], a_id[w], a_lock[w], a_prot[w]};
    for (int k = 0; k <= ar_wait; k++) begin
      router_axi_arready = (k == ar_wait);
      #1;
      check("ar_valid", router_axi_arvalid, 1);
      check("ar_fields", {router_axi_araddr, router_axi_arlen, router_axi_arsize,
                          router_axi_arburst, router_axi_arid, router_axi_arlock,
                          router_axi_arprot}, exp_ar);
      check("ar_ready", host_axi_arready, (k == ar_wait) ? (N'(1) << w) : '0);
      @(posedge clk); #1;
    end
    router_axi_arready = 1'b0;
    pend[w] = 1'b0;
`ifdef ARMLEOSOC_AXI_ARBITER_ROUND_ROBIN_EN
    rr_model = (w + 1) % N;
`endif
    exp_id = a_id[w];
    nb = int'(a_len[w]) + 1;
    for (int b = 0; b < nb; b++) begin
      beats.push_back($urandom);
      exp_q.push_back(beats[b]);
    end
    for (int h = 0; h < N; h++) begin
      if (raise[h] && !pend[h]) begin
        new_req(h);
        pend[h] = 1'b1;
      end
    end
    drive_ar();

    bi = 0; cyc = 0; got = 0; done = 0;
    while (!done && cyc < 200) begin
      if (bi == rst_beat) rst_n = 1'b0;
      router_axi_rvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      router_axi_rdata  = beats[bi];
      router_axi_rlast  = (bi == nb - 1);
      router_axi_rresp  = (bi == nb - 1) ? last_resp : OKAY;
      router_axi_rid    = exp_id;
      rdy = stall ? N'($urandom) : '1;
      host_axi_rready = rdy;
      #1;
      check("r_valid", host_axi_rvalid, router_axi_rvalid ? (N'(1) << w) : '0);
      check("r_ready", router_axi_rready, rdy[w]);
      if (host_axi_rvalid[w] && host_axi_rready[w]) begin
        got++;
        check("r_beat_in_range", got <= nb, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("r_data", host_axi_rdata, e);
          check("r_last", host_axi_rlast, exp_q.size() == 0);
          check("r_resp", host_axi_rresp, (exp_q.size() == 0) ? last_resp : OKAY);
          check("r_id", host_axi_rid, exp_id);
        end
      end
      if (router_axi_rvalid && router_axi_rready) begin
        if (bi == nb - 1) done = 1'b1;
        else bi++;
      end
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        // Reset was sampled on this edge: everything must be back to IDLE.
        router_axi_arready = 1'b1;
        router_axi_rvalid  = 1'b1;
        host_axi_rready    = '1;
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_arvalid", router_axi_arvalid, 0);
        check("rst_rready", router_axi_rready, 0);
        check("rst_host_rvalid", host_axi_rvalid, 0);
        check("rst_host_arready", host_axi_arready, 0);
        rst_n = 1'b1;
        router_axi_arready = 1'b0;
        router_axi_rvalid  = 1'b0;
        host_axi_rready    = '0;
        rr_model = 0;
        exp_q.delete();
        pend = '0;
        drive_ar();
        @(posedge clk); #1;
        return;
      end
    end
    check("r_no_timeout", done, 1);
    check("r_beat_count", got, nb);
    // Cycle after the rlast handshake: IDLE, nothing forwarded even though
    // the router still shows a valid beat.
    router_axi_rvalid = 1'b1;
    host_axi_rready   = '1;
    #1;
    check("turn_state", dbg_state, IDLE);
    check("turn_arvalid", router_axi_arvalid, 0);
    check("turn_host_rvalid", host_axi_rvalid, 0);
    router_axi_rvalid = 1'b0;
    host_axi_rready   = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  int g;
  int order_exp[4];

  initial begin
    rst_n = 1'b0;
    pend = '0;
    router_axi_arready = 1'b1;
    router_axi_rvalid  = 1'b1;
    router_axi_rresp = OKAY; router_axi_rlast = 1'b0;
    router_axi_rdata = '0;   router_axi_rid = '0;
    host_axi_rready = '1;
    new_req(0); new_req(1);
    drive_ar();
    repeat (3) @(posedge clk);
    #1;
    // Reset state: all handshakes low, AR payload shows host 0.
    check("reset_state", dbg_state, IDLE);
    check("reset_arvalid", router_axi_arvalid, 0);
    check("reset_rready", router_axi_rready, 0);
    check("reset_host_arready", host_axi_arready, 0);
    check("reset_host_rvalid", host_axi_rvalid, 0);
    check("reset_ar_mirror", {router_axi_araddr, router_axi_arid},
          {a_addr[0], a_id[0]});
    router_axi_arready = 1'b0;
    router_axi_rvalid  = 1'b0;
    host_axi_rready    = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single host 1: addr 0x1000, len 3, id 5.
    new_req(1);
    a_addr[1] = 34'h1000; a_len[1] = 8'd3; a_id[1] = 4'd5; a_burst[1] = INCR;
    pend = 2'b10;
    run_txn(0, 0, OKAY, '0, -1, g);
    check("single_grant", g, 1);

    // Simultaneous hosts 0 and 1, each re-requesting after its grant.
`ifdef ARMLEOSOC_AXI_ARBITER_ROUND_ROBIN_EN
    order_exp = '{0, 1, 0, 1};
`else
    order_exp = '{0, 0, 0, 0};
`endif
    new_req(0); new_req(1);
    a_addr[0] = 34'h2_0000_0000; a_addr[1] = 34'h0_0000_4000;
    pend = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 0, OKAY, (i < 3) ? 2'b11 : 2'b00, -1, g);
      check($sformatf("grant_order_%0d", i), g, order_exp[i]);
    end
    while (pend != 0) run_txn(0, 0, OKAY, '0, -1, g);

    // Backpressure: arready low for 5 cycles, rready/rvalid toggling.
    new_req(0); pend = 2'b01;
    run_txn(5, 1, OKAY, '0, -1, g);

    // Error pass-through on the last beat.
    new_req(1); pend = 2'b10;
    run_txn(0, 1, DECERR, '0, -1, g);

    // Turnaround: host 0 requests while host 1's burst ends.
    new_req(1); pend = 2'b10;
    run_txn(0, 0, OKAY, 2'b01, -1, g);
    run_txn(0, 0, SLVERR, '0, -1, g);
    check("turnaround_grant", g, 0);

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      if (pend == 0) begin
        pend = N'($urandom_range(1, (1 << N) - 1));
        for (int h = 0; h < N; h++) if (pend[h]) new_req(h);
      end
      run_txn($urandom_range(0, 3), 1, 2'($urandom), N'($urandom), -1, g);
    end
    while (pend != 0) run_txn(0, 1, OKAY, '0, -1, g);

    // Reset during beat 2 of an 8-beat burst, then a normal burst.
    new_req(0); a_len[0] = 8'd7; pend = 2'b01;
    run_txn(0, 0, OKAY, '0, 1, g);
    new_req(1); pend = 2'b10;
    run_txn(1, 1, OKAY, '0, -1, g);
    check("post_reset_grant", g, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
